// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg -- shared definitions for the branch predictor.
//   bp_cnt_e     : 2-bit saturating direction counter state (SNT/WNT/WT/ST)
//   BP_BIMODAL / BP_GSHARE : values of the predictor MODE parameter
//   bp_cnt_next  : saturating counter step for a resolved direction
// ---------------------------------------------------------------------------
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_cnt_e;

    localparam int BP_BIMODAL = 0;
    localparam int BP_GSHARE  = 1;

    // Taken moves toward ST, not-taken toward SNT; both ends stick.
    function automatic bp_cnt_e bp_cnt_next(input bp_cnt_e c, input logic taken);
        bp_cnt_e n;
        n = c;
        if (taken && c != ST)
            n = bp_cnt_e'(c + 2'd1);
        else if (!taken && c != SNT)
            n = bp_cnt_e'(c - 2'd1);
        return n;
    endfunction

endpackage

// File: rtl/bp_btb.sv
// ---------------------------------------------------------------------------
// bp_btb -- direct-mapped branch target buffer (only built when
// BRANCH_PRED_BTB_EN is defined in the top).
//   clk_i, rst_i       : clock, asynchronous active-low reset (clears valids)
//   rd_pc_i            : lookup PC; hit_o / target_o combinational
//   wr_en_i            : overwrite entry selected by wr_pc_i
//   wr_pc_i, wr_target_i : write PC (index + tag) and target
// Index pc[IDX_W+1:2], tag pc[ADDR_W-1:IDX_W+2].
// ---------------------------------------------------------------------------
module bp_btb #(
    parameter int ENTRIES = 64,
    parameter int ADDR_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] rd_pc_i,
    output logic              hit_o,
    output logic [ADDR_W-1:0] target_o,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_pc_i,
    input  logic [ADDR_W-1:0] wr_target_i
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [ADDR_W-1:0]  tgt_q [ENTRIES];

    logic [IDX_W-1:0] rd_idx, wr_idx;
    assign rd_idx = rd_pc_i[IDX_W+1:2];
    assign wr_idx = wr_pc_i[IDX_W+1:2];

    // Only the valid bits need reset; tag/target are qualified by them.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            valid_q <= '0;
        else if (wr_en_i)
            valid_q[wr_idx] <= 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            tag_q[wr_idx] <= wr_pc_i[ADDR_W-1:IDX_W+2];
            tgt_q[wr_idx] <= wr_target_i;
        end
    end

    assign hit_o    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_pc_i[ADDR_W-1:IDX_W+2]);
    assign target_o = hit_o ? tgt_q[rd_idx] : '0;

    logic unused_lsb;
    assign unused_lsb = ^{rd_pc_i[1:0], wr_pc_i[1:0]};

endmodule

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor -- bimodal (MODE=0) or gshare (MODE=1) direction
// predictor with 2-bit saturating counters, optional BTB.
// Optional feature macro: BRANCH_PRED_BTB_EN (builds bp_btb; taken
// predictions then also require a BTB hit).
// Ports:
//   clk_i, rst_i      : clock, asynchronous active-low reset
//   start_i           : enable; low gives not-taken and blocks updates
//   pred_pc_i         : IF-stage PC, prediction is combinational
//   pred_taken_o      : predicted direction
//   pred_target_o     : BTB target on hit (0 otherwise / without BTB)
//   pred_hit_o        : BTB tag hit (0 without BTB)
//   upd_valid_i, upd_pc_i, upd_taken_i, upd_pred_i, upd_target_i :
//                       one resolved branch per cycle
//   upd_cnt_o, miss_cnt_o : saturating resolved / mispredict counts
// ---------------------------------------------------------------------------
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int ADDR_W  = 32,
    parameter int MODE    = 0,
    parameter int GHR_W   = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] pred_pc_i,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_target_o,
    output logic              pred_hit_o,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic              upd_taken_i,
    input  logic              upd_pred_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    output logic [31:0]       upd_cnt_o,
    output logic [31:0]       miss_cnt_o
);
    localparam int IDX_W = $clog2(ENTRIES);

    bp_cnt_e          cnt_q [ENTRIES];
    logic [GHR_W-1:0] ghr_q;
    logic [31:0]      upd_cnt_q, miss_cnt_q;

    logic             upd_acc;
    logic [IDX_W-1:0] pred_idx, upd_idx;
    bp_cnt_e          pred_cnt;
    logic             dir_taken;

    // Gshare folds the history into the low index bits (zero-extended).
    function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] pc,
                                                input logic [GHR_W-1:0]  ghr);
        logic [IDX_W-1:0] f;
        f = pc[IDX_W+1:2];
        if (MODE == BP_GSHARE)
            f = f ^ IDX_W'(ghr);
        return f;
    endfunction

    assign upd_acc  = upd_valid_i & start_i;
    assign pred_idx = idx_of(pred_pc_i, ghr_q);
    assign upd_idx  = idx_of(upd_pc_i, ghr_q);   // pre-update history

    // Read straight from the registered table: a same-cycle update to the
    // same entry is not forwarded.
    assign pred_cnt  = cnt_q[pred_idx];
    assign dir_taken = start_i & pred_cnt[1];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < ENTRIES; i++)
                cnt_q[i] <= WNT;
        end else if (upd_acc) begin
            cnt_q[upd_idx] <= bp_cnt_next(cnt_q[upd_idx], upd_taken_i);
        end
    end

    // History is only advanced by resolved branches (non-speculative).
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            ghr_q <= '0;
        else if (upd_acc)
            ghr_q <= (ghr_q << 1) | GHR_W'(upd_taken_i);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            upd_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (upd_acc) begin
            if (upd_cnt_q != '1)
                upd_cnt_q <= upd_cnt_q + 32'd1;
            if ((upd_taken_i != upd_pred_i) && (miss_cnt_q != '1))
                miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign upd_cnt_o  = upd_cnt_q;
    assign miss_cnt_o = miss_cnt_q;

`ifdef BRANCH_PRED_BTB_EN
    logic              btb_hit;
    logic [ADDR_W-1:0] btb_tgt;

    bp_btb #(
        .ENTRIES (ENTRIES),
        .ADDR_W  (ADDR_W)
    ) u_btb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rd_pc_i     (pred_pc_i),
        .hit_o       (btb_hit),
        .target_o    (btb_tgt),
        .wr_en_i     (upd_acc & upd_taken_i),
        .wr_pc_i     (upd_pc_i),
        .wr_target_i (upd_target_i)
    );

    assign pred_taken_o  = dir_taken & btb_hit;
    assign pred_hit_o    = btb_hit;
    assign pred_target_o = btb_tgt;
`else
    assign pred_taken_o  = dir_taken;
    assign pred_hit_o    = 1'b0;
    assign pred_target_o = '0;
`endif

    logic unused_bits;
    assign unused_bits = ^{pred_pc_i, upd_pc_i, upd_target_i};

endmodule
